// File: rtl/memory.sv
// -----------------------------------------------------------------------------
// memory: single-port word memory with a valid/ready request handshake.
//
// A request is accepted on a rising clk edge where valid=1 and ready=0. ready
// pulses for the one cycle after the accepting edge, so a master that holds
// valid through the ready cycle still gets exactly one operation. Writes update
// the addressed word and leave rdata alone. Reads load rdata, which then holds
// until the next accepted read. Out-of-range addresses (addr >= DEPTH) drop
// writes and read as zero. Reset clears every word, rdata and ready.
//
// Optional feature (define MEM_PARITY_EN): each word carries an even-parity bit
// generated from wdata. par_inj flips the stored bit on a write, and perr
// pulses with ready on a read whose parity does not check.
//
// Parameters:
//   WIDTH       data word width in bits
//   DEPTH       number of storage words
//   ADDR_WIDTH  address width, 2**ADDR_WIDTH >= DEPTH
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous reset, active low
//   addr     word address of the request
//   wdata    write data
//   wr_rd    1 = write, 0 = read
//   valid    request strobe from the master
//   par_inj  (MEM_PARITY_EN only) invert stored parity on this write
//   perr     (MEM_PARITY_EN only) parity error, pulses with ready on a read
//   rdata    registered read data
//   ready    registered completion strobe, one cycle per accepted request
// -----------------------------------------------------------------------------
module memory #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  wr_rd,
    input  logic                  valid,
`ifdef MEM_PARITY_EN
    input  logic                  par_inj,
    output logic                  perr,
`endif
    output logic [WIDTH-1:0]      rdata,
    output logic                  ready
);

`ifdef MEM_PARITY_EN
    localparam int unsigned WordW = WIDTH + 1;
`else
    localparam int unsigned WordW = WIDTH;
`endif

    logic                 accept;
    logic [WordW-1:0]     wr_word;
    logic [WordW-1:0]     rd_word;
    logic [WordW-1:0]     mem_q [DEPTH];
    logic                 ready_q;
    logic                 ready_d;
    logic [WIDTH-1:0]     rdata_q;
    logic [WIDTH-1:0]     rdata_d;

    // No new request is taken in the ready cycle, so a held valid is one op.
    assign accept = valid & ~ready_q;

    always_comb begin
`ifdef MEM_PARITY_EN
        // Parity bit makes the stored word even; par_inj corrupts it on purpose.
        wr_word = {(^wdata) ^ par_inj, wdata};
`else
        wr_word = wdata;
`endif
    end

    // Decoded read mux: addresses with no matching word fall through to zero.
    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_WIDTH'(i)) begin
                rd_word = mem_q[i];
            end
        end
    end

    // Storage; a write to an address >= DEPTH matches no word and is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (accept && wr_rd) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (addr == ADDR_WIDTH'(i)) begin
                    mem_q[i] <= wr_word;
                end
            end
        end
    end

    always_comb begin
        ready_d = accept;
        rdata_d = rdata_q;
        if (accept && !wr_rd) begin
            rdata_d = rd_word[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_PARITY_EN
    logic perr_q;
    logic perr_d;

    // An odd reduction over data plus parity bit means the word fails its check.
    assign perr_d = accept & ~wr_rd & (^rd_word);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign perr = perr_q;
`endif

    assign ready = ready_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_memory.sv
// -----------------------------------------------------------------------------
// tb_memory: scoreboard bench for memory. dut0 uses the default geometry
// (DEPTH=32), dut1 uses DEPTH=20 for out-of-range addresses. Both share the
// request bus and reset and have separate valid strobes. The driver pushes an
// expected {rdata, perr, ready cycle} per request; a monitor pops and compares
// on every ready pulse.
// -----------------------------------------------------------------------------
module tb_memory;

    typedef struct {
        logic [15:0] rdata;
        logic        perr;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  addr = '0;
    logic [15:0] wdata = '0;
    logic        wr_rd = 1'b0;
    logic        valid0 = 1'b0;
    logic        valid1 = 1'b0;
    logic [15:0] rdata0, rdata1;
    logic        ready0, ready1;
    logic        perr0, perr1;
`ifdef MEM_PARITY_EN
    logic        par_inj = 1'b0;
`endif

    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] m0 [32];
    logic [15:0] m1 [20];
    bit          p0 [32];
    bit          p1 [20];
    logic [15:0] last0, last1;

    memory #(.WIDTH(16), .DEPTH(32), .ADDR_WIDTH(5)) dut0 (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .wdata  (wdata),
        .wr_rd  (wr_rd),
        .valid  (valid0),
`ifdef MEM_PARITY_EN
        .par_inj(par_inj),
        .perr   (perr0),
`endif
        .rdata  (rdata0),
        .ready  (ready0)
    );

    memory #(.WIDTH(16), .DEPTH(20), .ADDR_WIDTH(5)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .wdata  (wdata),
        .wr_rd  (wr_rd),
        .valid  (valid1),
`ifdef MEM_PARITY_EN
        .par_inj(par_inj),
        .perr   (perr1),
`endif
        .rdata  (rdata1),
        .ready  (ready1)
    );

`ifndef MEM_PARITY_EN
    assign perr0 = 1'b0;
    assign perr1 = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m0[i] = '0;
            p0[i] = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            m1[i] = '0;
            p1[i] = 1'b0;
        end
        last0 = '0;
        last1 = '0;
    endtask

    // Called just after a clock edge; the request is accepted on the next edge
    // and the task returns just after the following (ready-cycle) edge.
    task automatic req(input bit sel, input int a, input logic [15:0] d, input bit w,
                       input bit inj, input bit hold);
        exp_t e;
        int   depth;
        depth = sel ? 20 : 32;
        addr  = a[4:0];
        wdata = d;
        wr_rd = w;
`ifdef MEM_PARITY_EN
        par_inj = inj;
`endif
        if (sel) valid1 = 1'b1;
        else valid0 = 1'b1;
        e.cyc  = cyc + 1;
        e.perr = 1'b0;
        if (w) begin
            if (a < depth) begin
                if (sel) begin
                    m1[a] = d;
                    p1[a] = inj;
                end else begin
                    m0[a] = d;
                    p0[a] = inj;
                end
            end
            e.rdata = sel ? last1 : last0;
        end else begin
            e.rdata = '0;
            if (a < depth) begin
                e.rdata = sel ? m1[a] : m0[a];
                e.perr  = sel ? p1[a] : p0[a];
            end
            if (sel) last1 = e.rdata;
            else last0 = e.rdata;
        end
        if (sel) q1.push_back(e);
        else q0.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) begin
            valid0 = 1'b0;
            valid1 = 1'b0;
        end
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && ready0 === 1'b1) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ready0: got ready=1 expected no pulse at cyc %0d", cyc);
            end else begin
                e = q0.pop_front();
                chk("dut0_rdata_perr_cyc", {15'd0, rdata0, perr0, cyc}, {15'd0, e.rdata, e.perr, e.cyc});
            end
        end
        if (rst === 1'b1 && ready1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ready1: got ready=1 expected no pulse at cyc %0d", cyc);
            end else begin
                e = q1.pop_front();
                chk("dut1_rdata_perr_cyc", {15'd0, rdata1, perr1, cyc}, {15'd0, e.rdata, e.perr, e.cyc});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        // Reset held low for 10 ns; outputs must be zero while it is low.
        #1 rst = 1'b0;
        #5;
        chk("reset_ready0", ready0, 0);
        chk("reset_rdata0", rdata0, 0);
        chk("reset_ready1", ready1, 0);
        chk("reset_rdata1", rdata1, 0);
        #5 rst = 1'b1;

        // First request lands on the first edge after reset release.
        for (int k = 0; k < 32; k++) req(0, k, 16'h0000, 0, 0, 0);

        // Back-to-back writes then reads with valid held continuously.
        for (int k = 0; k < 32; k++) req(0, k, 16'hA500 + 16'(k), 1, 0, 1);
        for (int k = 0; k < 32; k++) req(0, k, 16'h0000, 0, 0, 1);

        // Held valid through the ready cycle gives one write, then read back.
        req(0, 3, 16'h1234, 1, 0, 1);
        req(0, 3, 16'h0000, 0, 0, 0);

        // Out-of-range on the 20-word instance, plus its last valid word.
        req(1, 25, 16'hFFFF, 1, 0, 0);
        req(1, 25, 16'h0000, 0, 0, 0);
        req(1, 19, 16'hBEEF, 1, 0, 0);
        req(1, 20, 16'h1111, 1, 0, 0);
        req(1, 20, 16'h0000, 0, 0, 0);
        req(1, 19, 16'h0000, 0, 0, 0);

        // Reset inside the ready cycle of a write aborts the pulse.
        addr   = 5'd5;
        wdata  = 16'h00AA;
        wr_rd  = 1'b1;
        valid0 = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_before_abort", ready0, 1);
        #1 rst = 1'b0;
        valid0 = 1'b0;
        #1;
        chk("ready_abort", ready0, 0);
        chk("rdata_abort", rdata0, 0);
        model_reset();
        rst = 1'b1;
        req(0, 5, 16'h0000, 0, 0, 0);
        req(0, 3, 16'h0000, 0, 0, 0);

`ifdef MEM_PARITY_EN
        req(0, 7, 16'h0001, 1, 1, 0);
        req(0, 7, 16'h0000, 0, 0, 0);
        req(0, 7, 16'h0001, 1, 0, 0);
        req(0, 7, 16'h0000, 0, 0, 0);
`endif

        // Idle inputs with valid low must not produce any ready pulse.
        addr  = 5'd9;
        wdata = 16'h5555;
        wr_rd = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        req(0, 9, 16'h0000, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("q0_final", q0.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
